// File: rtl/mem_req_ctrl_pkg.sv
// Shared types for the RAM request front-end: command/response records and controller states.
package mem_ctrl_pkg;

    localparam int ADDR_W     = 4;
    localparam int DATA_W     = 32;
    // Edges from a registered read to its data being sampled back from the RAM.
    localparam int RD_LATENCY = 2;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] addr;
    } rsp_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } ctrl_state_e;

endpackage

// File: rtl/mem_req_ctrl_if.sv
// Request and response valid/ready channels between a client and mem_req_ctrl.
interface mem_req_ctrl_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic [ADDR_WIDTH-1:0] rsp_addr;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_addr
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_addr
    );
endinterface

// File: rtl/mem_req_ctrl_sync_fifo.sv
// Registered-pointer FIFO, no fall-through; a pop on empty is ignored, a push on full
// is accepted only when a pop frees the slot in the same cycle. clear empties it.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [PW:0]      cnt;
    logic             do_push, do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == (PW+1)'(DEPTH));
    assign count   = cnt;
    assign rdata   = store[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            cnt <= cnt + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) store[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/mem_req_ctrl.sv
// In-order request front-end for the single-port RAM: command FIFO -> registered issue -> response FIFO.
// Reads issue only while a response slot is reserved for them, so the response FIFO never overflows.
module mem_req_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_W,
    parameter int DATA_WIDTH = DATA_W,
    parameter int CMD_DEPTH  = 4,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_req_ctrl_if.slave         bus,
    input  logic                  flush,
    output logic                  mem_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_valid,
    output logic                  busy,
    output logic                  err
);
    localparam int CW = $clog2(RSP_DEPTH) + 2;

    ctrl_state_e state, state_nxt;
    cmd_t        cmd_in, cmd_head;
    rsp_t        rsp_in, rsp_head;
    logic        cmd_full, cmd_empty, rsp_full, rsp_empty;
    logic [$clog2(CMD_DEPTH):0] cmd_count;
    logic [$clog2(RSP_DEPTH):0] rsp_count;
    logic [RD_LATENCY-1:0]      rd_pend;
    logic [ADDR_WIDTH-1:0]      rd_addr [RD_LATENCY];
    logic [CW-1:0]              in_use;
    logic        has_credit, issue, accept, rsp_pop;

    // Reserved slots: entries already held plus reads still travelling through the RAM.
    assign in_use     = CW'(rsp_count) + CW'(rd_pend[0]) + CW'(rd_pend[1]);
    assign has_credit = !rsp_full && (in_use < CW'(RSP_DEPTH));
    assign issue      = !cmd_empty && !flush && (cmd_head.write || has_credit);

    assign bus.req_ready = !flush && (state != DRAIN) && (!cmd_full || issue);
    assign accept        = bus.req_valid && bus.req_ready;
    assign cmd_in        = '{write: bus.req_write, addr: bus.req_addr, wdata: bus.req_wdata};

    sync_fifo #(.WIDTH($bits(cmd_t)), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk(clk), .rst(rst), .clear(flush),
        .push(accept), .wdata(cmd_in), .pop(issue), .rdata(cmd_head),
        .full(cmd_full), .empty(cmd_empty), .count(cmd_count)
    );

    assign rsp_in  = '{data: mem_rdata, addr: rd_addr[RD_LATENCY-1]};
    assign rsp_pop = bus.rsp_ready && !rsp_empty;

    sync_fifo #(.WIDTH($bits(rsp_t)), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
        .clk(clk), .rst(rst), .clear(1'b0),
        .push(rd_pend[RD_LATENCY-1]), .wdata(rsp_in), .pop(rsp_pop), .rdata(rsp_head),
        .full(rsp_full), .empty(rsp_empty), .count(rsp_count)
    );

    assign bus.rsp_valid = !rsp_empty;
    assign bus.rsp_data  = rsp_head.data;
    assign bus.rsp_addr  = rsp_head.addr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_en     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            rd_pend    <= '0;
            rd_addr[0] <= '0;
            rd_addr[1] <= '0;
            err        <= 1'b0;
        end else begin
            mem_en <= issue && cmd_head.write;
            if (issue) begin
                mem_addr  <= cmd_head.addr;
                mem_wdata <= cmd_head.write ? cmd_head.wdata : '0;
            end
            rd_pend <= {rd_pend[0], issue && !cmd_head.write};
            if (issue && !cmd_head.write) rd_addr[0] <= cmd_head.addr;
            rd_addr[1] <= rd_addr[0];
            // mem_valid is also high on idle cycles, so it is only judged when a read is due.
            if (rd_pend[RD_LATENCY-1] && !mem_valid) err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (cmd_empty && (rd_pend == '0) && !accept) state_nxt = IDLE;
            DRAIN:   if (rd_pend == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = DRAIN;
    end

    assign busy = (state != IDLE) || (cmd_count != '0) || !rsp_empty || (rd_pend != '0);
endmodule

// File: tb/tb_mem_req_ctrl.sv
// Scoreboarded bench for mem_req_ctrl with a behavioural single-port RAM attached.
module tb_mem_req_ctrl;
    import mem_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush, mem_en, mem_valid, busy, err, corrupt;
    logic [3:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [31:0] ram [16];
    rsp_t        exp_q [$];
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    mem_req_ctrl_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) bus ();

    mem_req_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .CMD_DEPTH(4), .RSP_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .bus(bus), .flush(flush),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_valid(mem_valid), .busy(busy), .err(err)
    );

    // RAM: samples pins at the edge; Valid_out only after a non-write cycle.
    initial begin
        for (int i = 0; i < 16; i++) ram[i] = '0;
        mem_rdata = '0;
        mem_valid = 1'b0;
    end

    always @(posedge clk) begin
        if (mem_en) begin
            ram[mem_addr] <= mem_wdata;
            mem_valid     <= 1'b0;
        end else begin
            mem_rdata <= ram[mem_addr];
            mem_valid <= !corrupt;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin : monitor
        rsp_t e;
        if (rst && bus.rsp_valid && bus.rsp_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rsp actual=%0h@%0h required=none", bus.rsp_data, bus.rsp_addr);
            end else begin
                e = exp_q.pop_front();
                check("rsp_data", 64'(bus.rsp_data), 64'(e.data));
                check("rsp_addr", 64'(bus.rsp_addr), 64'(e.addr));
            end
        end
    end

    task automatic send(input logic wr, input logic [3:0] a, input logic [31:0] d,
                        input logic exp_en, input logic [31:0] exp_d);
        int n = 0;
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = a;
        bus.req_wdata = d;
        @(negedge clk);
        while (!bus.req_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!bus.req_ready) check("req_accept_timeout", 64'(bus.req_ready), 64'd1);
        else if (exp_en) exp_q.push_back('{data: exp_d, addr: a});
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] exp_d);
        send(1'b0, a, 32'd0, 1'b1, exp_d);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        send(1'b1, a, d, 1'b0, 32'd0);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            n++;
            @(negedge clk);
        end
        repeat (8) @(negedge clk);
        check(name, 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lat, run, w, n;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b1;
        flush   = 1'b0;
        corrupt = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_en", 64'(mem_en), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        #3 rst = 1'b1;
        @(negedge clk);
        check("rst_req_ready", 64'(bus.req_ready), 64'd1);
        check("rst_err", 64'(err), 64'd0);
        @(posedge clk);
        #1;

        // Eight back-to-back reads of a cleared RAM; responses must stream without gaps.
        fork
            for (int i = 0; i < 8; i++) rd(4'(i), 32'd0);
            begin
                run = 0;
                w = 0;
                while (!bus.rsp_valid && w < 50) begin
                    @(negedge clk);
                    w++;
                end
                while (bus.rsp_valid && run < 20) begin
                    run++;
                    @(negedge clk);
                end
                check("b2b_valid_run", 64'(run), 64'd8);
            end
        join
        wait_drain("b2b_drain");

        // Write then read the same address; response three edges after acceptance.
        wr(4'd3, 32'hDEADBEEF);
        rd(4'd3, 32'hDEADBEEF);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!bus.rsp_valid && lat < 20);
        check("rd_latency", 64'(lat), 64'd3);
        wait_drain("wr_rd_drain");
        check("wr_rd_err", 64'(err), 64'd0);

        wr(4'd15, 32'h1);
        wr(4'd0, 32'h2);
        rd(4'd15, 32'h1);
        rd(4'd0, 32'h2);
        wait_drain("wrap_drain");

        // Backpressure: four reads fill the response side, four more fill the command FIFO.
        bus.rsp_ready = 1'b0;
        rd(4'd3, 32'hDEADBEEF);
        rd(4'd15, 32'h1);
        rd(4'd0, 32'h2);
        rd(4'd1, 32'h0);
        rd(4'd2, 32'h0);
        rd(4'd4, 32'h0);
        rd(4'd5, 32'h0);
        rd(4'd6, 32'h0);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 4'd7;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_req_ready", 64'(bus.req_ready), 64'd0);
            check("bp_rsp_valid", 64'(bus.rsp_valid), 64'd1);
            check("bp_hold_data", 64'(bus.rsp_data), 64'hDEADBEEF);
            check("bp_hold_addr", 64'(bus.rsp_addr), 64'd3);
        end
        bus.req_valid = 1'b0;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b1;
        wait_drain("bp_drain");

        // Flush with one read issued and three still queued.
        bus.rsp_ready = 1'b0;
        rd(4'd1, 32'h0);
        rd(4'd2, 32'h0);
        rd(4'd4, 32'h0);
        repeat (4) @(posedge clk);
        #1;
        rd(4'd3, 32'hDEADBEEF);
        send(1'b0, 4'd15, 32'd0, 1'b0, 32'd0);
        send(1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
        send(1'b0, 4'd5, 32'd0, 1'b0, 32'd0);
        @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        check("flush_req_ready", 64'(bus.req_ready), 64'd0);
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("flush_busy_held", 64'(busy), 64'd1);
        @(posedge clk);
        #1 bus.rsp_ready = 1'b1;
        wait_drain("flush_drain");
        n = 0;
        while (busy && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("flush_busy_fall", 64'(busy), 64'd0);
        @(posedge clk);
        #1;

        // A read returning without Valid_out sets the sticky error.
        corrupt = 1'b1;
        rd(4'd3, 32'hDEADBEEF);
        wait_drain("err_drain");
        corrupt = 1'b0;
        check("err_sticky", 64'(err), 64'd1);

        // Async reset between edges with reads in flight and a response held.
        bus.rsp_ready = 1'b0;
        send(1'b0, 4'd15, 32'd0, 1'b0, 32'd0);
        send(1'b0, 4'd3, 32'd0, 1'b0, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        #2 rst = 1'b0;
        #1;
        check("arst_mem_en", 64'(mem_en), 64'd0);
        check("arst_mem_addr", 64'(mem_addr), 64'd0);
        check("arst_mem_wdata", 64'(mem_wdata), 64'd0);
        check("arst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("arst_err", 64'(err), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        #2 rst = 1'b1;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rd(4'd5, 32'h0);
        wait_drain("post_rst_drain");
        check("post_rst_err", 64'(err), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
